simon_flash_player: RTL and testbench
=====================================

// Module: simon_flash_player
// PURPOSE
//  Downstream of the game state machine. Its gColor output changes every clock during GET_COLOR; this block
//  buffers those colour codes in a FIFO and replays each one for a human-visible ON period, followed by a blank
//  gap. Its output drives the VGA/LED colour renderer. The game asserts In_Valid once per sequence step.
// PARAMETERS
//  DEPTH       16          FIFO entries; power of 2, >=2; covers max sequence (10) plus margin
//  ON_CYCLES   50_000_000  clocks each colour is shown (0.5 s @100 MHz); >=1
//  OFF_CYCLES  25_000_000  clocks of blank gap after each colour; >=1
// PORTS
//  Clk          in   1  system clock, rising edge
//  Reset        in   1  asynchronous, active-high; clears all state
//  Clear        in   1  synchronous flush (game returns to INITIAL/LOST/EXIT)
//  In_Valid     in   1  In_Color valid this cycle
//  In_Color     in   3  colour code: 1=RED 2=BLUE 3=YELLOW 4=GREEN; 0 and 5-7 ignored
//  In_Ready     out  1  FIFO not full (= !full; no same-cycle pop passthrough)
//  Flash_Color  out  3  colour being displayed; 0 = blank
//  Flash_Active out  1  high exactly while in SHOW
//  Busy         out  1  (state != IDLE) || FIFO not empty
//  Done_Pulse   out  1  1-cycle pulse: last gap ended with FIFO empty
//  Overflow     out  1  sticky: valid colour offered while full
// BEHAVIOUR
//  Reset values: all outputs 0 except In_Ready=1; FIFO empty; state IDLE; counter 0.
//  Push: In_Valid && In_Color in 1..4 && !full && !Clear -> write at the clock edge. Invalid codes are dropped silently.
//  Push when full: data dropped; Overflow<=1 (sticky until Reset/Clear).
//  FSM states: IDLE, SHOW, GAP (registered outputs).
//   IDLE: if !empty -> pop head, Flash_Color<=head, cnt<=ON_CYCLES-1, go to SHOW.
//   SHOW: cnt!=0 -> cnt--. cnt==0 -> Flash_Color<=0, cnt<=OFF_CYCLES-1, go to GAP.
//   GAP:  cnt!=0 -> cnt--. cnt==0 && !empty -> pop, go to SHOW directly (no IDLE cycle).
//         cnt==0 && empty -> go to IDLE, Done_Pulse<=1 for one cycle.
//  Timing: push at edge N into an empty, idle block -> pop at edge N+1 -> Flash_Color valid from N+1 for exactly
//   ON_CYCLES cycles, then 0 for exactly OFF_CYCLES cycles. Back-to-back period = ON_CYCLES+OFF_CYCLES.
//  Simultaneous push+pop: both occur; count unchanged. When count==DEPTH, In_Ready stays low even during a pop.
//  Order is strictly FIFO; pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
//  Clear: dominates push/pop; same edge -> FIFO empty, IDLE, Flash_Color=0, cnt=0, Overflow=0, no Done_Pulse.
//  Reset asserted mid-flash: outputs go to reset values immediately (asynchronously); no Done_Pulse on release.
//  cnt width = clog2(max(ON_CYCLES,OFF_CYCLES)).
// CONFIGURATION
//  FLASH_PLAYER_CNT_EN defined: adds output Shown_Count[7:0]. It increments on each SHOW->GAP transition,
//   saturates at 255, and is zeroed by Reset/Clear.
//  Undefined: the port and its logic are absent. All other behaviour is identical.
// STRUCTURE
//  simon_defs.vh (shared with puvvada side): COLOR_W=3, COLOR_NONE=0, RED=1, BLUE=2, YELLOW=3, GREEN=4, and
//   FSM state encodings.
//  Sub-module flash_fifo: synchronous FIFO (DEPTH, width 3) with push/pop/clear, full/empty, and head data.
//   The top level holds the FSM, timer, and flags.
// TESTING (use ON_CYCLES=4, OFF_CYCLES=2, DEPTH=4)
//  1 Single push 3 at edge N -> Flash_Color=3 for cycles N+1..N+4; 0 for 2 cycles; Done_Pulse on next cycle; Busy low after.
//  2 Push 1,2,4 on consecutive cycles -> shows 1,2,4 every 6 cycles; no IDLE between; one Done_Pulse at the end.
//  3 Push 5 pushes of valid colours while idle -> first pops at N+1, so 5th may fit; then push while count==4 -> Overflow=1, data lost, order kept.
//  4 Push In_Color=0 and 7 -> ignored; Busy stays 0; Overflow 0.
//  5 Clear during SHOW with 2 queued, plus a push on the same cycle -> next cycle Flash_Color=0, IDLE, empty, no Done_Pulse.
//  6 Reset pulse mid-GAP -> asynchronous return to reset values; a fresh push then plays normally (and Shown_Count restarts at 0 if enabled).

Source files
------------

// File: rtl/simon_flash_player_pkg.sv
// -----------------------------------------------------------------------------
// simon_flash_player_pkg
// Shared definitions for the Simon flash player: colour code width and values,
// player FSM state encoding, and a colour-validity helper.
// -----------------------------------------------------------------------------
package simon_flash_player_pkg;

  localparam int COLOR_W = 3;

  localparam logic [COLOR_W-1:0] COLOR_NONE   = 3'd0;
  localparam logic [COLOR_W-1:0] COLOR_RED    = 3'd1;
  localparam logic [COLOR_W-1:0] COLOR_BLUE   = 3'd2;
  localparam logic [COLOR_W-1:0] COLOR_YELLOW = 3'd3;
  localparam logic [COLOR_W-1:0] COLOR_GREEN  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Only RED..GREEN are real colours; anything else is dropped at the input.
  function automatic logic is_valid_color(input logic [COLOR_W-1:0] c);
    return (c >= COLOR_RED) && (c <= COLOR_GREEN);
  endfunction

endpackage

// File: rtl/simon_flash_player_fifo.sv
// -----------------------------------------------------------------------------
// flash_fifo
// Small synchronous FIFO holding colour codes waiting to be flashed.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_clear        synchronous flush; dominates push and pop
//   i_push/i_data  write request and data (ignored when full)
//   i_pop          read request (ignored when empty)
//   o_full/o_empty occupancy flags
//   o_head         data at the read pointer (valid while !o_empty)
// -----------------------------------------------------------------------------
module flash_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Full is decided on the current count only, so a pop never frees a slot
  // for a push in the same cycle.
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == {(AW+1){1'b0}});
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full && !i_clear;
  assign w_do_pop  = i_pop && !o_empty && !i_clear;

  // Storage array; written only on an accepted push.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else if (i_clear) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/simon_flash_player.sv
// -----------------------------------------------------------------------------
// simon_flash_player
// Buffers colour codes from the game FSM and replays each one for ON_CYCLES
// clocks followed by an OFF_CYCLES blank gap.
// Ports:
//   Clk, Reset    clock, asynchronous active-high reset
//   Clear         synchronous flush back to idle/empty
//   In_Valid      In_Color valid this cycle
//   In_Color      colour code 1..4 (others dropped)
//   In_Ready      FIFO not full
//   Flash_Color   colour on display, 0 = blank
//   Flash_Active  high while a colour is shown
//   Busy          player not idle or FIFO holds entries
//   Done_Pulse    one cycle after the last gap ends with nothing queued
//   Overflow      sticky: a valid colour was offered while full
//   Shown_Count   (only with FLASH_PLAYER_CNT_EN) saturating count of shows
// Build option: define FLASH_PLAYER_CNT_EN to add Shown_Count.
// -----------------------------------------------------------------------------
module simon_flash_player
  import simon_flash_player_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ON_CYCLES  = 50_000_000,
  parameter int OFF_CYCLES = 25_000_000
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Clear,
  input  logic         In_Valid,
  input  logic [2:0]   In_Color,
  output logic         In_Ready,
  output logic [2:0]   Flash_Color,
  output logic         Flash_Active,
  output logic         Busy,
  output logic         Done_Pulse,
`ifdef FLASH_PLAYER_CNT_EN
  output logic [7:0]   Shown_Count,
`endif
  output logic         Overflow
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

  state_e               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [COLOR_W-1:0]   r_flash_color, w_flash_color_nxt;
  logic                 r_active;
  logic                 r_done, w_done_nxt;
  logic                 r_overflow, w_overflow_nxt;
  logic                 w_show_end;
  logic                 w_offer;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [COLOR_W-1:0]   w_head;

  assign w_offer = In_Valid && is_valid_color(In_Color);
  assign w_push  = w_offer && !w_full && !Clear;

  flash_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (COLOR_W)
  ) u_fifo (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_clear (Clear),
    .i_push  (w_push),
    .i_data  (In_Color),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Next-state, timer and output decode; Clear overrides everything last.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_flash_color_nxt = r_flash_color;
    w_done_nxt        = 1'b0;
    w_pop             = 1'b0;
    w_show_end        = 1'b0;
    w_overflow_nxt    = r_overflow | (w_offer && w_full);

    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop             = 1'b1;
          w_flash_color_nxt = w_head;
          w_cnt_nxt         = ON_LOAD;
          w_state_nxt       = ST_SHOW;
        end else begin
          w_flash_color_nxt = COLOR_NONE;
        end
      end
      ST_SHOW: begin
        if (r_cnt != {CNT_W{1'b0}}) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_flash_color_nxt = COLOR_NONE;
          w_cnt_nxt         = OFF_LOAD;
          w_state_nxt       = ST_GAP;
          w_show_end        = 1'b1;
        end
      end
      ST_GAP: begin
        if (r_cnt != {CNT_W{1'b0}}) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (!w_empty) begin
          // Chain straight into the next colour without an idle cycle.
          w_pop             = 1'b1;
          w_flash_color_nxt = w_head;
          w_cnt_nxt         = ON_LOAD;
          w_state_nxt       = ST_SHOW;
        end else begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt       = ST_IDLE;
        w_cnt_nxt         = {CNT_W{1'b0}};
        w_flash_color_nxt = COLOR_NONE;
      end
    endcase

    if (Clear) begin
      w_state_nxt       = ST_IDLE;
      w_cnt_nxt         = {CNT_W{1'b0}};
      w_flash_color_nxt = COLOR_NONE;
      w_done_nxt        = 1'b0;
      w_pop             = 1'b0;
      w_show_end        = 1'b0;
      w_overflow_nxt    = 1'b0;
    end else begin
      w_overflow_nxt = w_overflow_nxt;
    end
  end

  // State, timer and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= {CNT_W{1'b0}};
      r_flash_color <= COLOR_NONE;
      r_active      <= 1'b0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_flash_color <= w_flash_color_nxt;
      r_active      <= (w_state_nxt == ST_SHOW);
      r_done        <= w_done_nxt;
      r_overflow    <= w_overflow_nxt;
    end
  end

`ifdef FLASH_PLAYER_CNT_EN
  logic [7:0] r_shown_count;

  // Saturating count of completed SHOW periods.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_shown_count <= 8'd0;
    end else if (Clear) begin
      r_shown_count <= 8'd0;
    end else if (w_show_end && (r_shown_count != 8'd255)) begin
      r_shown_count <= r_shown_count + 8'd1;
    end else begin
      r_shown_count <= r_shown_count;
    end
  end

  assign Shown_Count = r_shown_count;
`endif

  assign Flash_Color  = r_flash_color;
  assign Flash_Active = r_active;
  assign Done_Pulse   = r_done;
  assign Overflow     = r_overflow;
  assign In_Ready     = !w_full;
  assign Busy         = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_simon_flash_player.sv
// -----------------------------------------------------------------------------
// tb_simon_flash_player
// Directed self-checking bench for simon_flash_player with DEPTH=4,
// ON_CYCLES=4, OFF_CYCLES=2. Expected display timing comes from a small
// slot/phase model; FIFO occupancy and overflow come from a counter model.
// -----------------------------------------------------------------------------
module tb_simon_flash_player;

  localparam int DEPTH  = 4;
  localparam int ON     = 4;
  localparam int OFF    = 2;
  localparam int PERIOD = ON + OFF;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Clear;
  logic       In_Valid;
  logic [2:0] In_Color;
  logic       In_Ready;
  logic [2:0] Flash_Color;
  logic       Flash_Active;
  logic       Busy;
  logic       Done_Pulse;
  logic       Overflow;
`ifdef FLASH_PLAYER_CNT_EN
  logic [7:0] Shown_Count;
`endif

  simon_flash_player #(
    .DEPTH      (DEPTH),
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Clear        (Clear),
    .In_Valid     (In_Valid),
    .In_Color     (In_Color),
    .In_Ready     (In_Ready),
    .Flash_Color  (Flash_Color),
    .Flash_Active (Flash_Active),
    .Busy         (Busy),
    .Done_Pulse   (Done_Pulse),
`ifdef FLASH_PLAYER_CNT_EN
    .Shown_Count  (Shown_Count),
`endif
    .Overflow     (Overflow)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] seq_q [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Push seq_q[0..n_push-1] on consecutive edges starting at edge N (i=0) and
  // check every cycle until one cycle past the expected Done_Pulse.
  task automatic play(input int n_push, input int n_items, input string name);
    int occ;
    int last;
    int slot;
    int ph;
    bit full_b;
    bit push_ok;
    bit do_pop;
    logic ovf;
    logic [2:0] exp_color;
    logic exp_active;
    occ  = 0;
    ovf  = 1'b0;
    last = PERIOD * n_items + 1;
    for (int i = 0; i <= last + 1; i++) begin
      if (i < n_push) begin
        In_Valid = 1'b1;
        In_Color = seq_q[i];
      end else begin
        In_Valid = 1'b0;
        In_Color = 3'd0;
      end
      full_b  = (occ == DEPTH);
      push_ok = (i < n_push) && !full_b;
      if ((i < n_push) && full_b) ovf = 1'b1;
      do_pop  = (i >= 1) && (((i - 1) % PERIOD) == 0) && (((i - 1) / PERIOD) < n_items);
      occ     = occ + (push_ok ? 1 : 0) - (do_pop ? 1 : 0);
      tick();
      exp_color  = 3'd0;
      exp_active = 1'b0;
      if (i >= 1) begin
        slot = (i - 1) / PERIOD;
        ph   = (i - 1) % PERIOD;
        if (slot < n_items && ph < ON) begin
          exp_color  = seq_q[slot];
          exp_active = 1'b1;
        end
      end
      check($sformatf("%s color i=%0d", name, i), Flash_Color, exp_color);
      check($sformatf("%s active i=%0d", name, i), Flash_Active, exp_active);
      check($sformatf("%s done i=%0d", name, i), Done_Pulse, (i == last));
      check($sformatf("%s busy i=%0d", name, i), Busy, (i < last));
      check($sformatf("%s ready i=%0d", name, i), In_Ready, (occ < DEPTH));
      check($sformatf("%s ovf i=%0d", name, i), Overflow, ovf);
    end
    In_Valid = 1'b0;
  endtask

  initial begin
    Reset    = 1'b1;
    Clear    = 1'b0;
    In_Valid = 1'b0;
    In_Color = 3'd0;
    tick();
    tick();
    check("rst color", Flash_Color, 3'd0);
    check("rst active", Flash_Active, 1'b0);
    check("rst busy", Busy, 1'b0);
    check("rst done", Done_Pulse, 1'b0);
    check("rst ovf", Overflow, 1'b0);
    check("rst ready", In_Ready, 1'b1);
`ifdef FLASH_PLAYER_CNT_EN
    check("rst shown", Shown_Count, 8'd0);
`endif
    Reset = 1'b0;
    tick();

    // 1: single colour
    seq_q[0] = 3'd3;
    play(1, 1, "t1");
`ifdef FLASH_PLAYER_CNT_EN
    check("t1 shown", Shown_Count, 8'd1);
`endif

    // 2: three colours back to back
    seq_q[0] = 3'd1; seq_q[1] = 3'd2; seq_q[2] = 3'd4;
    play(3, 3, "t2");
`ifdef FLASH_PLAYER_CNT_EN
    check("t2 shown", Shown_Count, 8'd4);
`endif

    // 3: five pushes fit, sixth overflows and is lost
    seq_q[0] = 3'd1; seq_q[1] = 3'd2; seq_q[2] = 3'd3;
    seq_q[3] = 3'd4; seq_q[4] = 3'd1; seq_q[5] = 3'd2;
    play(6, 5, "t3");
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    check("t3 ovf cleared", Overflow, 1'b0);
    check("t3 busy after clear", Busy, 1'b0);
`ifdef FLASH_PLAYER_CNT_EN
    check("t3 shown cleared", Shown_Count, 8'd0);
`endif

    // 4: invalid codes dropped
    seq_q[0] = 3'd0; seq_q[1] = 3'd7; seq_q[2] = 3'd5;
    for (int k = 0; k < 3; k++) begin
      In_Valid = 1'b1;
      In_Color = seq_q[k];
      tick();
      In_Valid = 1'b0;
      tick();
      check($sformatf("t4 busy k=%0d", k), Busy, 1'b0);
      check($sformatf("t4 ovf k=%0d", k), Overflow, 1'b0);
      check($sformatf("t4 color k=%0d", k), Flash_Color, 3'd0);
      check($sformatf("t4 ready k=%0d", k), In_Ready, 1'b1);
    end

    // 5: Clear during SHOW with two queued and a push on the same edge
    seq_q[0] = 3'd1; seq_q[1] = 3'd2; seq_q[2] = 3'd3;
    for (int k = 0; k < 3; k++) begin
      In_Valid = 1'b1;
      In_Color = seq_q[k];
      tick();
    end
    check("t5 showing", Flash_Color, 3'd1);
    Clear    = 1'b1;
    In_Valid = 1'b1;
    In_Color = 3'd4;
    tick();
    Clear    = 1'b0;
    In_Valid = 1'b0;
    check("t5 color", Flash_Color, 3'd0);
    check("t5 active", Flash_Active, 1'b0);
    check("t5 busy", Busy, 1'b0);
    check("t5 done", Done_Pulse, 1'b0);
    check("t5 ready", In_Ready, 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("t5 idle color k=%0d", k), Flash_Color, 3'd0);
      check($sformatf("t5 idle done k=%0d", k), Done_Pulse, 1'b0);
      check($sformatf("t5 idle busy k=%0d", k), Busy, 1'b0);
    end
`ifdef FLASH_PLAYER_CNT_EN
    check("t5 shown", Shown_Count, 8'd0);
`endif

    // 6: asynchronous reset mid-GAP, then a fresh flash
    In_Valid = 1'b1; In_Color = 3'd2;
    tick();
    In_Valid = 1'b1; In_Color = 3'd3;
    tick();
    In_Valid = 1'b0;
    for (int k = 2; k <= 5; k++) tick();
    check("t6 in gap color", Flash_Color, 3'd0);
    check("t6 in gap busy", Busy, 1'b1);
`ifdef FLASH_PLAYER_CNT_EN
    check("t6 shown before rst", Shown_Count, 8'd1);
`endif
    Reset = 1'b1;
    #1;
    check("t6 async busy", Busy, 1'b0);
    check("t6 async ready", In_Ready, 1'b1);
    check("t6 async color", Flash_Color, 3'd0);
    check("t6 async active", Flash_Active, 1'b0);
    check("t6 async done", Done_Pulse, 1'b0);
`ifdef FLASH_PLAYER_CNT_EN
    check("t6 async shown", Shown_Count, 8'd0);
`endif
    tick();
    Reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("t6 post done k=%0d", k), Done_Pulse, 1'b0);
      check($sformatf("t6 post busy k=%0d", k), Busy, 1'b0);
    end
    seq_q[0] = 3'd4;
    play(1, 1, "t6");
`ifdef FLASH_PLAYER_CNT_EN
    check("t6 shown", Shown_Count, 8'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
